// File: rtl/cp0_intc.sv
// rtl/cp0_intc.sv - CP0-style interrupt controller with synchronised lines, timer and priority grant
module cp0_intc #(
  parameter int NUM_INT     = 6,
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2,
  localparam int ID_W       = $clog2(NUM_INT + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_INT-1:0] intr,
  input  logic               we,
  input  logic [2:0]         addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  input  logic               ack,
  output logic               excpt_req,
  output logic [ID_W-1:0]    excpt_id,
  output logic               intimer
);

  logic [NUM_INT-1:0] sync_q [SYNC_STAGES];
  logic [NUM_INT-1:0] sync_prev;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   compare;
  logic [NUM_INT:0]   mask;
  logic [NUM_INT:0]   pending;
  logic [NUM_INT-1:0] mode;
  logic               ie;
  logic               exl;

  logic               wr_count, wr_compare, wr_mask, wr_mode, wr_pending, wr_status;
  logic [NUM_INT:0]   candidate;
  logic [NUM_INT:0]   grant_oh;
  logic [ID_W-1:0]    gid;
  logic               accept;
  logic               timer_hit;
  logic [NUM_INT-1:0] sync_val;
  logic [NUM_INT-1:0] rise;
  logic [NUM_INT-1:0] edge_clr;
  logic [NUM_INT-1:0] line_next;
  logic               unused_bits;

  assign wr_count   = we && (addr == 3'd0);
  assign wr_compare = we && (addr == 3'd1);
  assign wr_mask    = we && (addr == 3'd2);
  assign wr_mode    = we && (addr == 3'd3);
  assign wr_pending = we && (addr == 3'd4);
  assign wr_status  = we && (addr == 3'd5);

  assign candidate = pending & mask;
  assign excpt_req = ie && !exl && (|candidate);
  assign intimer   = pending[NUM_INT];

  // Lowest index wins: scan from the top so the last hit is the smallest index.
  always_comb begin
    gid = '0;
    for (int i = NUM_INT; i >= 0; i--) begin
      if (candidate[i]) gid = ID_W'(i);
    end
  end

  assign excpt_id  = excpt_req ? gid : '0;
  assign grant_oh  = {{NUM_INT{1'b0}}, 1'b1} << gid;
  assign accept    = ack && excpt_req;
  assign timer_hit = (count == compare) && (compare != '0);

  assign sync_val  = sync_q[SYNC_STAGES-1];
  assign rise      = sync_val & ~sync_prev;
  assign edge_clr  = (wr_pending ? wdata[NUM_INT-1:0] : '0)
                   | (accept ? grant_oh[NUM_INT-1:0] : '0);
  // Edge lines: a fresh rising edge beats any clear in the same cycle.
  assign line_next = (mode & ((pending[NUM_INT-1:0] & ~edge_clr) | rise))
                   | (~mode & sync_val);

  assign unused_bits = ^{wdata, grant_oh[NUM_INT]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= intr;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_prev <= '0;
      count     <= '0;
      compare   <= '0;
      mask      <= '0;
      mode      <= '0;
      pending   <= '0;
      ie        <= 1'b0;
      exl       <= 1'b0;
    end else begin
      sync_prev <= sync_val;
      count     <= wr_count ? wdata[CNT_W-1:0] : count + CNT_W'(1);
      if (wr_compare) compare <= wdata[CNT_W-1:0];
      if (wr_mask)    mask    <= wdata[NUM_INT:0];
      if (wr_mode)    mode    <= wdata[NUM_INT-1:0];
      pending[NUM_INT-1:0] <= line_next;
      // Only a COMPARE write retires the timer, and it overrides a same-cycle hit.
      if (wr_compare)     pending[NUM_INT] <= 1'b0;
      else if (timer_hit) pending[NUM_INT] <= 1'b1;
      if (wr_status) begin
        ie  <= wdata[0];
        exl <= wdata[1];
      end
      if (accept) exl <= 1'b1;
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      3'd0:    rdata[CNT_W-1:0]   = count;
      3'd1:    rdata[CNT_W-1:0]   = compare;
      3'd2:    rdata[NUM_INT:0]   = mask;
      3'd3:    rdata[NUM_INT-1:0] = mode;
      3'd4:    rdata[NUM_INT:0]   = pending;
      3'd5:    rdata[1:0]         = {exl, ie};
      default: rdata = '0;
    endcase
  end

endmodule
